mdu: RTL and testbench

- Multiply/divide unit in the EX stage, beside the ALU; consumes the same two forwarded register operands (operand1 = rs, operand2 = rt).
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and holds the HI/LO architectural registers.
- Exposes busy so hazard control stalls subsequent MDU instructions; hi/lo are read for MFHI/MFLO and muxed into the EX result path.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 71 +++++++
 rtl/mdu.sv | 131 +++++++++++++
 tb/tb_mdu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU opcode codes, default latencies and state type for the EX-stage multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
package mdu_pkg;

    localparam logic [3:0] MDUOP_NONE  = 4'd0;
    localparam logic [3:0] MDUOP_MULT  = 4'd1;
    localparam logic [3:0] MDUOP_MULTU = 4'd2;
    localparam logic [3:0] MDUOP_DIV   = 4'd3;
    localparam logic [3:0] MDUOP_DIVU  = 4'd4;
    localparam logic [3:0] MDUOP_MTHI  = 4'd5;
    localparam logic [3:0] MDUOP_MTLO  = 4'd6;
    localparam logic [3:0] MDUOP_MADD  = 4'd7;
    localparam logic [3:0] MDUOP_MADDU = 4'd8;
    localparam logic [3:0] MDUOP_MSUB  = 4'd9;
    localparam logic [3:0] MDUOP_MSUBU = 4'd10;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct when read as unsigned.
    function automatic logic [31:0] mdu_abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: products, shared signed/unsigned divider and optional accumulate.
// MDU_MADD_EN adds the {hi,lo} +/- product path.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] pending,
    output logic        div_by_zero
);

    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic        sdiv_s;
    logic        zero_s;
    logic [31:0] divisor_s;
    logic [31:0] dividend_mag_s;
    logic [31:0] divisor_mag_s;
    logic [31:0] quot_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    assign sprod_s = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    assign uprod_s = {32'd0, operand1} * {32'd0, operand2};

    // One unsigned divider serves both DIV and DIVU; signed mode feeds magnitudes and fixes signs after.
    assign sdiv_s         = (op == MDUOP_DIV);
    assign zero_s         = (operand2 == 32'd0);
    assign divisor_s      = zero_s ? 32'd1 : operand2;
    assign dividend_mag_s = sdiv_s ? mdu_abs32(operand1)  : operand1;
    assign divisor_mag_s  = sdiv_s ? mdu_abs32(divisor_s) : divisor_s;
    assign quot_mag_s     = dividend_mag_s / divisor_mag_s;
    assign rem_mag_s      = dividend_mag_s % divisor_mag_s;
    assign quot_s = (sdiv_s && (operand1[31] ^ divisor_s[31])) ? (32'd0 - quot_mag_s) : quot_mag_s;
    assign rem_s  = (sdiv_s && operand1[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;

`ifndef MDU_MADD_EN
    logic unused_s;
    assign unused_s = ^{hi, lo, MDUOP_MADD, MDUOP_MADDU, MDUOP_MSUB, MDUOP_MSUBU};
`endif

    // Select the value the top latches into pending for the requested operation.
    always_comb begin
        pending     = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MDUOP_MULT:  pending = sprod_s;
            MDUOP_MULTU: pending = uprod_s;
            MDUOP_DIV,
            MDUOP_DIVU: begin
                pending     = {rem_s, quot_s};
                div_by_zero = zero_s;
            end
`ifdef MDU_MADD_EN
            MDUOP_MADD:  pending = {hi, lo} + sprod_s;
            MDUOP_MADDU: pending = {hi, lo} + uprod_s;
            MDUOP_MSUB:  pending = {hi, lo} - sprod_s;
            MDUOP_MSUBU: pending = {hi, lo} - uprod_s;
`endif
            default: begin
                pending     = 64'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: fixed-latency countdown, pending result and HI/LO registers.
// MDU_MADD_EN enables the multiply-accumulate opcodes (latency MULT_CYCLES).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [CW-1:0] count_r, count_s;
    logic [63:0]   pending_r, pending_s;
    logic          commit_r, commit_s;
    logic [31:0]   hi_r, hi_s;
    logic [31:0]   lo_r, lo_s;
    logic          busy_r;
    logic [63:0]   calc_s;
    logic          dbz_s;
    mdu_state_t    state_s;

    mdu_calc u_calc (
        .op          (mdu_op),
        .operand1    (operand1),
        .operand2    (operand2),
        .hi          (hi_r),
        .lo          (lo_r),
        .pending     (calc_s),
        .div_by_zero (dbz_s)
    );

    assign state_s = (count_r != CNT_ZERO) ? MDU_RUN : MDU_IDLE;

    // Next-state logic: accept a request in IDLE, count down in RUN and commit on the 1->0 step.
    always_comb begin
        count_s   = count_r;
        pending_s = pending_r;
        commit_s  = commit_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        case (state_s)
            MDU_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        MDUOP_MULT,
                        MDUOP_MULTU: begin
                            pending_s = calc_s;
                            commit_s  = 1'b1;
                            count_s   = MULT_LOAD;
                        end
                        MDUOP_DIV,
                        MDUOP_DIVU: begin
                            pending_s = calc_s;
                            commit_s  = ~dbz_s;
                            count_s   = DIV_LOAD;
                        end
                        MDUOP_MTHI: hi_s = operand1;
                        MDUOP_MTLO: lo_s = operand1;
`ifdef MDU_MADD_EN
                        MDUOP_MADD,
                        MDUOP_MADDU,
                        MDUOP_MSUB,
                        MDUOP_MSUBU: begin
                            pending_s = calc_s;
                            commit_s  = 1'b1;
                            count_s   = MULT_LOAD;
                        end
`endif
                        default: count_s = count_r;
                    endcase
                end else begin
                    count_s = count_r;
                end
            end
            MDU_RUN: begin
                // start is ignored here; hazard control should never issue one while busy.
                count_s = count_r - CNT_ONE;
                if (count_r == CNT_ONE) begin
                    commit_s = 1'b0;
                    if (commit_r) begin
                        {hi_s, lo_s} = pending_r;
                    end else begin
                        hi_s = hi_r;
                    end
                end else begin
                    commit_s = commit_r;
                end
            end
            default: count_s = CNT_ZERO;
        endcase
    end

    // State and architectural registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= CNT_ZERO;
            pending_r <= 64'd0;
            commit_r  <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            count_r   <= count_s;
            pending_r <= pending_s;
            commit_r  <= commit_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            busy_r    <= (count_s != CNT_ZERO);
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan steps plus random ops against an arithmetic model.
// Build with +define+MDU_MADD_EN to exercise the accumulate opcodes.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdu_op   (mdu_op),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: latency and resulting {hi,lo} from the architectural rules.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc, output logic [63:0] nv);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, sp, up, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = sa * sb;
        up = ua * ub;
        acc = {mhi, mlo};
        nv = acc;
        cyc = 0;
        case (op)
            4'd1: begin cyc = MC; nv = sp; end
            4'd2: begin cyc = MC; nv = up; end
            4'd3: begin
                cyc = DC;
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    nv = {sr[31:0], sq[31:0]};
                end
            end
            4'd4: begin
                cyc = DC;
                if (b != 32'd0) nv = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: nv = {a, mlo};
            4'd6: nv = {mhi, a};
`ifdef MDU_MADD_EN
            4'd7:  begin cyc = MC; nv = acc + sp; end
            4'd8:  begin cyc = MC; nv = acc + up; end
            4'd9:  begin cyc = MC; nv = acc - sp; end
            4'd10: begin cyc = MC; nv = acc - up; end
`endif
            default: nv = acc;
        endcase
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_op = op; operand1 = a; operand2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
    endtask

    // Issue one op and check busy/hold every cycle, then the committed value.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [63:0] nv, old;
        model_op(op, a, b, cyc, nv);
        old = {mhi, mlo};
        issue(op, a, b);
        for (int i = 0; i < cyc; i++) begin
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            chk({tag, "_hold"}, {hi, lo}, old);
            @(negedge clk);
        end
        {mhi, mlo} = nv;
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, nv);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; operand1 = 32'd0; operand2 = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        run("mult", 4'd1, 32'hFFFF_FFFD, 32'd5);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu", 4'd4, 32'hFFFF_FFF9, 32'd2);
        chk("divu_const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
        run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // Back-to-back MTHI/MTLO: zero latency, busy never rises.
        @(negedge clk);
        mdu_op = 4'd5; operand1 = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        chk("mthi_val", {32'd0, hi}, 64'h0000_0000_1234_5678);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        mdu_op = 4'd6; operand1 = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        chk("mtlo_val", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        {mhi, mlo} = 64'h1234_5678_9ABC_DEF0;
        run("div0", 4'd3, 32'd77, 32'd0);
        chk("div0_const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // MULTU with a DIV start arriving at busy cycle 2, which must be ignored.
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < MC; i++) begin
            chk("ign_busy", {63'd0, busy}, 64'd1);
            if (i == 1) begin
                mdu_op = 4'd3; operand1 = 32'd8; operand2 = 32'd2; start = 1'b1;
            end else begin
                start = 1'b0; mdu_op = 4'd0;
            end
            @(negedge clk);
        end
        chk("ign_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("ign_idle", {63'd0, busy}, 64'd0);
        repeat (DC) @(negedge clk);
        chk("ign_nolate", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        {mhi, mlo} = 64'hFFFF_FFFE_0000_0001;

        // Asynchronous reset at busy cycle 3 of a DIV.
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        {mhi, mlo} = 64'd0;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            chk("arst_nocommit", {31'd0, busy, hi}, 64'd0);
        end

`ifdef MDU_MADD_EN
        run("madd_mthi", 4'd5, 32'd0, 32'd0);
        run("madd_mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run("maddu", 4'd8, 32'd1, 32'd1);
        chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
        run("msub", 4'd9, 32'd1, 32'd2);
        chk("msub_const", {hi, lo}, 64'h0000_0000_FFFF_FFFE);
`else
        run("seed_hi", 4'd5, 32'hCAFE_0001, 32'd0);
        run("op7_nop", 4'd7, 32'd3, 32'd4);
        chk("op7_const", {hi, lo}, {32'hCAFE_0001, 32'd0});
`endif

        for (int n = 0; n < 60; n++) begin
            run("rand", 4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
